// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, reads instruction memory one word at a time and
// buffers {instr, pc} pairs in an in-order queue drained by decode; redirect flushes and restarts.
module fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_ren,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [31:0]   fetch_pc;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];

    logic          push;
    logic          pop;

    // Low address bits of a redirect target are dropped; word alignment is forced.
    logic          unused_rpc_bits;
    assign unused_rpc_bits = ^redirect_pc[1:0];

    assign mem_ren     = reset & ~redirect & (count < CW'(DEPTH));
    assign mem_addr    = fetch_pc;
    assign instr_valid = (count != '0);

    // Push/pop are qualified by redirect so a flush discards both.
    assign push = mem_ren & mem_ready;
    assign pop  = instr_valid & instr_ready & ~redirect;

    always_comb begin
        instr    = 32'h0;
        instr_pc = 32'h0;
        if (instr_valid) begin
            instr    = instr_mem[head];
            instr_pc = pc_mem[head];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                tail     <= tail + 1'b1;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue payload needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clock) begin
        if (push) begin
            instr_mem[tail] <= mem_rdata;
            pc_mem[tail]    <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit: boot, backpressure, wait states, redirect,
// asynchronous reset, plus a PC wrap-around sequence on a second instance.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic        reset2;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_ready;
    logic        instr_ready;

    logic        mem_ren,     mem_ren2;
    logic [31:0] mem_addr,    mem_addr2;
    logic [31:0] mem_rdata,   mem_rdata2;
    logic [31:0] instr,       instr2;
    logic [31:0] instr_pc,    instr_pc2;
    logic        instr_valid, instr_valid2;

    int n_checks;
    int n_fail;

    // Instruction memory contents as a pure function of the word address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign mem_rdata  = memf(mem_addr);
    assign mem_rdata2 = memf(mem_addr2);

    fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clock       (clock),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_ren     (mem_ren),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    fetch_unit #(.DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clock       (clock),
        .reset       (reset2),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_ren     (mem_ren2),
        .mem_addr    (mem_addr2),
        .mem_rdata   (mem_rdata2),
        .mem_ready   (mem_ready),
        .instr       (instr2),
        .instr_pc    (instr_pc2),
        .instr_valid (instr_valid2),
        .instr_ready (instr_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        mrdy;
        logic        irdy;
        logic        ren;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic redir, input logic [31:0] rpc,
                       input logic mrdy, input logic irdy, input logic ren,
                       input logic [31:0] addr, input logic vld, input logic [31:0] pc);
        vec_t v;
        v.rst = rst; v.redir = redir; v.rpc = rpc; v.mrdy = mrdy; v.irdy = irdy;
        v.ren = ren; v.addr = addr; v.vld = vld; v.pc = pc;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic chk_wrap(input int step, input logic ren, input logic [31:0] addr,
                            input logic vld, input logic [31:0] pc);
        chk("wrap_mem_ren", step, {31'b0, mem_ren2}, {31'b0, ren});
        chk("wrap_mem_addr", step, mem_addr2, addr);
        chk("wrap_instr_valid", step, {31'b0, instr_valid2}, {31'b0, vld});
        chk("wrap_instr_pc", step, instr_pc2, pc);
        chk("wrap_instr", step, instr2, vld ? memf(pc) : 32'h0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        reset2      = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        mem_ready   = 1'b1;
        instr_ready = 1'b1;
        #1;
        reset  = 1'b0;
        reset2 = 1'b0;

        //   rst redir rpc           mrdy irdy | ren addr          vld pc
        // Reset and boot stream
        add(0, 0, 32'h0,         1, 1,   0, 32'h0,         0, 32'h0);
        add(1, 0, 32'h0,         1, 1,   1, 32'h0,         0, 32'h0);
        add(1, 0, 32'h0,         1, 1,   1, 32'h4,         1, 32'h0);
        add(1, 0, 32'h0,         1, 1,   1, 32'h8,         1, 32'h4);
        add(1, 0, 32'h0,         1, 1,   1, 32'hC,         1, 32'h8);
        add(1, 0, 32'h0,         1, 1,   1, 32'h10,        1, 32'hC);
        add(1, 0, 32'h0,         1, 1,   1, 32'h14,        1, 32'h10);
        // Redirect to 0, then backpressure for 6 cycles
        add(1, 1, 32'h0,         1, 0,   0, 32'h18,        1, 32'h14);
        add(1, 0, 32'h0,         1, 0,   1, 32'h0,         0, 32'h0);
        add(1, 0, 32'h0,         1, 0,   1, 32'h4,         1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            add(1, 0, 32'h0,     1, 0,   0, 32'h8,         1, 32'h0);
        end
        add(1, 0, 32'h0,         1, 1,   0, 32'h8,         1, 32'h0);
        add(1, 0, 32'h0,         1, 1,   1, 32'h8,         1, 32'h4);
        add(1, 0, 32'h0,         1, 1,   1, 32'hC,         1, 32'h8);
        // Redirect to 0, then mem_ready 1,0,0,1,0,1
        add(1, 1, 32'h0,         1, 1,   0, 32'h10,        1, 32'hC);
        add(1, 0, 32'h0,         1, 1,   1, 32'h0,         0, 32'h0);
        add(1, 0, 32'h0,         0, 1,   1, 32'h4,         1, 32'h0);
        add(1, 0, 32'h0,         0, 1,   1, 32'h4,         0, 32'h0);
        add(1, 0, 32'h0,         1, 1,   1, 32'h4,         0, 32'h0);
        add(1, 0, 32'h0,         0, 1,   1, 32'h8,         1, 32'h4);
        add(1, 0, 32'h0,         1, 1,   1, 32'h8,         0, 32'h0);
        add(1, 0, 32'h0,         1, 0,   1, 32'hC,         1, 32'h8);
        // Redirect with two entries queued; unaligned target
        add(1, 1, 32'h103,       1, 1,   0, 32'h10,        1, 32'h8);
        add(1, 0, 32'h0,         1, 1,   1, 32'h100,       0, 32'h0);
        add(1, 0, 32'h0,         1, 1,   1, 32'h104,       1, 32'h100);
        // Redirect held two cycles: last target wins
        add(1, 1, 32'h200,       1, 1,   0, 32'h108,       1, 32'h104);
        add(1, 1, 32'h304,       1, 1,   0, 32'h200,       0, 32'h0);
        add(1, 0, 32'h0,         1, 1,   1, 32'h304,       0, 32'h0);
        add(1, 0, 32'h0,         1, 1,   1, 32'h308,       1, 32'h304);
        // Fill queue, then asynchronous reset between edges
        add(1, 0, 32'h0,         1, 0,   1, 32'h30C,       1, 32'h308);
        add(1, 0, 32'h0,         1, 0,   0, 32'h310,       1, 32'h308);
        add(0, 0, 32'h0,         1, 0,   0, 32'h0,         0, 32'h0);
        add(1, 0, 32'h0,         1, 1,   1, 32'h0,         0, 32'h0);
        add(1, 0, 32'h0,         1, 1,   1, 32'h4,         1, 32'h0);
        add(1, 0, 32'h0,         1, 1,   1, 32'h8,         1, 32'h4);

        // Inputs change 1 time unit after posedge; outputs sampled on negedge.
        for (int r = 0; r < vq.size(); r++) begin
            @(posedge clock);
            #1;
            reset       = vq[r].rst;
            redirect    = vq[r].redir;
            redirect_pc = vq[r].rpc;
            mem_ready   = vq[r].mrdy;
            instr_ready = vq[r].irdy;
            @(negedge clock);
            chk("mem_ren", r, {31'b0, mem_ren}, {31'b0, vq[r].ren});
            chk("mem_addr", r, mem_addr, vq[r].addr);
            chk("instr_valid", r, {31'b0, instr_valid}, {31'b0, vq[r].vld});
            chk("instr_pc", r, instr_pc, vq[r].pc);
            chk("instr", r, instr, vq[r].vld ? memf(vq[r].pc) : 32'h0);
        end

        // PC wrap-around on the second instance, held in reset until now
        @(posedge clock);
        #1;
        redirect    = 1'b0;
        mem_ready   = 1'b1;
        instr_ready = 1'b1;
        @(negedge clock);
        chk_wrap(0, 1'b0, 32'hFFFF_FFF8, 1'b0, 32'h0);
        @(posedge clock);
        #1;
        reset2 = 1'b1;
        @(negedge clock);
        chk_wrap(1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
        @(negedge clock);
        chk_wrap(2, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8);
        @(negedge clock);
        chk_wrap(3, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC);
        @(negedge clock);
        chk_wrap(4, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the main/ALU decoders. It owns the fetch program counter, issues word reads to the instruction memory, and buffers returned instructions with their PCs in a small in-order queue. The decode stage drains the queue through a valid/ready handshake, and a redirect input flushes the queue and restarts fetch at a new PC for branches and jumps.

## Interface
- DEPTH, 2, queue entries; power of two, minimum 2
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset; bits [1:0] must be 0

- clock  in  1  system clock; all state changes on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately
- redirect  in  1  flush queue, load fetch PC from redirect_pc at next posedge
- redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and forced to 0
- mem_ren  out  1  instruction memory read enable (memory wen is tied 0 externally)
- mem_addr  out  32  byte address of the word being fetched; always equals fetch_pc
- mem_rdata  in  32  instruction word returned by memory
- mem_ready  in  1  mem_rdata is valid this cycle; tie high for the single-cycle memory
- instr  out  32  instruction at queue head; 0 when instr_valid = 0
- instr_pc  out  32  byte address of instr; 0 when instr_valid = 0
- instr_valid  out  1  queue non-empty
- instr_ready  in  1  decode accepts head entry this cycle

## Operation
- State consists of fetch_pc (32b), a DEPTH-entry queue of {instr, pc}, head/tail pointers (log2(DEPTH) bits, wrap modulo DEPTH), and count (0..DEPTH).
- Reset (reset = 0, asynchronous): fetch_pc = RESET_PC, count = 0, pointers = 0, mem_ren = 0, instr_valid = 0, instr = 0, instr_pc = 0, mem_addr = RESET_PC.
- mem_ren = reset & ~redirect & (count < DEPTH). This is combinational and does not depend on instr_ready. There is no full-queue bypass.
- Push: mem_ren & mem_ready at posedge. The block writes {mem_rdata, fetch_pc} at the tail, increments the tail, and sets fetch_pc = fetch_pc + 4 (32-bit modulo, so 32'hFFFF_FFFC wraps to 0).
- Pop: instr_valid & instr_ready at posedge. The block increments the head.
- Push and pop in the same cycle leave count unchanged. Push alone increments count, pop alone decrements it.
- mem_ready = 0 while mem_ren = 1 is a wait state. mem_addr and mem_ren hold, and no push occurs.
- Redirect at posedge has priority over everything:
  - count = 0, head = tail = 0, fetch_pc = {redirect_pc[31:2], 2'b00}.
  - Any pop and any returning data that cycle are discarded.
  - An outstanding waited request is abandoned.
- Redirect held for multiple cycles keeps the queue empty, with the last redirect_pc winning.
- instr_valid = (count != 0). instr and instr_pc are read from the head entry; they are forced to 0 when empty.
- Queue contents never reorder: instructions leave in strict ascending fetch order between redirects.

## Timing
- First fetch: mem_ren rises combinationally as soon as reset is released. The first instruction is captured at the first posedge after release and is presented at RESET_PC with instr_valid = 1 in the following cycle.
- Fetch-to-decode latency: 1 cycle from accepted memory read (mem_ren & mem_ready) to instr_valid.
- Throughput: 1 instruction/cycle sustained with mem_ready = 1 and instr_ready = 1. Count stays at 1.
- Decode stall (instr_ready = 0): the queue fills in DEPTH cycles, then mem_ren = 0 and fetch_pc holds. Releasing the stall restarts fetch the cycle after the first pop.
- Redirect latency: redirect at edge N; the first instruction from the new PC has instr_valid = 1 after edge N+1. This gives a two-cycle bubble.
- Reset asserted mid-operation: outputs take their reset values immediately, without waiting for a clock edge. Queued entries are lost.

## Test plan
- Reset/boot: RESET_PC = 0; mem_rdata = mem[addr>>2] from a table; mem_ready = 1; instr_ready = 1. Release reset, then 5 cycles -> instr_pc sequence 0, 4, 8, 12, 16 on consecutive cycles, instr matching the table, instr_valid continuous after the first.
- Backpressure: instr_ready = 0 for 6 cycles, DEPTH = 2 -> exactly 2 pushes (pc 0, 4), then mem_ren = 0 and mem_addr = 8 held. Raise instr_ready -> pc 0, 4, 8 drained in order with no loss or duplication.
- Wait states: mem_ready toggles 1,0,0,1,0,1 -> mem_addr held during each 0; instr_pc outputs 0, 4, 8 with no duplicates.
- Redirect: redirect = 1, redirect_pc = 32'h0000_0103 while the queue holds 2 entries and instr_ready = 1 -> next cycle instr_valid = 0, mem_addr = 32'h100. The cycle after that instr_pc = 32'h100.
- Wrap: RESET_PC = 32'hFFFF_FFF8 -> instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Asynchronous reset mid-stream: reset low between clock edges with 2 entries queued -> instr_valid, mem_ren, instr, and instr_pc go to 0 immediately. After release, fetch restarts at RESET_PC.
